dcache_load_resp: RTL and testbench
===================================

DCACHE_LOAD_RESP -- requirements
Module: dcache_load_resp

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, rising edge.
REQ-002 SHALL have: rst_n  in  1  reset, asynchronous, active-low.
REQ-003 SHALL have: req_valid  in  1  load request from memory1.
REQ-004 SHALL have: req_pa  in  32  physical byte address.
REQ-005 SHALL have: req_uncached  in  1  uncached load, single word access.
REQ-006 SHALL have: req_ready  out  1  request accepted when req_valid&req_ready.
REQ-007 SHALL have: rd_req  out  1 / rd_type  out  1 (0=word, 1=4-word line) / rd_addr  out  32  bus read request.
REQ-008 SHALL have: rd_rdy  in  1  bus accepts rd_req this cycle.
REQ-009 SHALL have: ret_valid  in  1 / ret_last  in  1 / ret_data  in  32  bus return beats.
REQ-010 SHALL have: rd_dcache_data  out  32 / dcache_data_valid  out  1 / dcache_data_ready  in  1  response to memory2.
REQ-011 SHALL have: flush_i  in  1  pipeline flush; inv_valid  in  1 / inv_pa  in  32  store-side line invalidate.

Function
REQ-012 SHALL implement FSM IDLE, BUS_REQ, BUS_WAIT, RESP; req_ready = (state==IDLE) & ~flush_i.
REQ-013 SHALL hold one line buffer: tag[27:0] (pa[31:4]), 4x32 data, line_vld.
REQ-014 Accept in IDLE, cached, line_vld & tag==req_pa[31:4]: hit; next state RESP, data = word req_pa[3:2]; dcache_data_valid high the cycle after accept.
REQ-015 Accept, cached miss: BUS_REQ, rd_type=1, rd_addr={req_pa[31:4],4'b0}; line_vld cleared on accept.
REQ-016 Accept, uncached: BUS_REQ, rd_type=0, rd_addr=req_pa; never hits, never touches line buffer.
REQ-017 BUS_REQ: rd_req held high, rd_addr/rd_type stable, until rd_rdy; then BUS_WAIT.
REQ-018 BUS_WAIT: line beats written to word 0..3 by 2-bit beat counter (wraps at 4); ret_valid&ret_last -> line_vld=1, tag written, state RESP.
REQ-019 RESP data: cached = word pa[3:2] of filled line; uncached = the single beat; valid the cycle after ret_last.
REQ-020 RESP: valid and data held stable until dcache_data_ready; on ready -> IDLE; no new request accepted same cycle.
REQ-021 flush_i in RESP: valid drops next cycle, -> IDLE, data discarded.
REQ-022 flush_i in BUS_REQ without rd_rdy: -> IDLE, request withdrawn; with rd_rdy same cycle: request counted as issued, cancel flag set.
REQ-023 flush_i in BUS_WAIT: cancel flag set; beats still consumed, line still filled; on ret_last -> IDLE, no response.
REQ-024 flush_i in IDLE with req_valid: request not accepted.
REQ-025 inv_valid & inv_pa[31:4]==tag: line_vld cleared next cycle; if same cycle as ret_last fill of that line, invalidate wins (line_vld=0, response still returned).
REQ-026 ret_valid outside BUS_WAIT SHALL be ignored.

Reset
REQ-027 rst_n low SHALL asynchronously force: state IDLE, line_vld 0, cancel 0, beat counter 0, rd_req 0, dcache_data_valid 0, rd_dcache_data 0, rd_addr 0, rd_type 0; req_ready 1 after release.
REQ-028 Reset mid-burst SHALL drop the transaction; no response after release.

Configuration
REQ-029 Macro DCACHE_LINE_BUF_EN defined: line buffer per REQ-013..025.
REQ-030 Not defined: no line buffer; every load is a word read (rd_type=0, rd_addr=req_pa), no hits, inv_valid ignored; all other timing unchanged.

Verification
REQ-031 Cached load pa=0x1C00_0104, empty buffer, ret 0x11,0x22,0x33,0x44 -> rd_addr 0x1C00_0100, rd_type 1, response 0x22.
REQ-032 Follow-up cached load pa=0x1C00_010C -> no rd_req, dcache_data_valid cycle after accept, data 0x44.
REQ-033 Response with dcache_data_ready low 3 cycles -> valid/data stable 3 cycles, IDLE after ready.
REQ-034 flush_i during BUS_WAIT beat 2 -> all 4 beats consumed, no dcache_data_valid, next load to same line hits.
REQ-035 Uncached load pa=0xBFAF_8000, ret 0xDEAD_BEEF -> rd_type 0, rd_addr 0xBFAF_8000, data 0xDEAD_BEEF, line buffer unchanged.
REQ-036 inv_pa=0x1C00_0108 after REQ-031 fill -> next load 0x1C00_0104 misses and issues rd_req.

Source files
------------

// File: rtl/dcache_load_resp.sv
// -----------------------------------------------------------------------------
// dcache_load_resp
//
// Load-response engine for the data cache. A load from memory1 is accepted in
// IDLE and is either served from a single-line buffer (hit) or turned into a
// bus read. The returned data is presented to memory2 with a valid/ready
// handshake. A pipeline flush withdraws or cancels the load in flight.
// Store-side invalidates clear the line buffer.
//
// Configuration macro: DCACHE_LINE_BUF_EN
//   defined   : one-line buffer (28-bit tag, 4 x 32-bit words, valid bit).
//               Cached misses fetch a 4-word line. Uncached loads fetch a word.
//   undefined : no line buffer. Every load is a single-word bus read at
//               req_pa, nothing ever hits, and inv_valid/inv_pa are ignored.
//
// Ports
//   clk, rst_n              clock (rising edge), asynchronous active-low reset
//   req_valid/req_ready     load request handshake from memory1
//   req_pa, req_uncached    physical byte address, uncached attribute
//   rd_req/rd_rdy           bus read request handshake
//   rd_type, rd_addr        0 = word read at rd_addr, 1 = 4-word line read
//   ret_valid/last/data     bus return beats (only observed in BUS_WAIT)
//   rd_dcache_data,
//   dcache_data_valid/ready response to memory2
//   flush_i                 pipeline flush
//   inv_valid, inv_pa       line invalidate from the store side
// -----------------------------------------------------------------------------
module dcache_load_resp (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    input  logic [31:0] req_pa,
    input  logic        req_uncached,
    output logic        req_ready,
    output logic        rd_req,
    output logic        rd_type,
    output logic [31:0] rd_addr,
    input  logic        rd_rdy,
    input  logic        ret_valid,
    input  logic        ret_last,
    input  logic [31:0] ret_data,
    output logic [31:0] rd_dcache_data,
    output logic        dcache_data_valid,
    input  logic        dcache_data_ready,
    input  logic        flush_i,
    input  logic        inv_valid,
    input  logic [31:0] inv_pa
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_BUS_REQ  = 2'd1,
        S_BUS_WAIT = 2'd2,
        S_RESP     = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_state_next;

    logic        r_cancel;      // load was flushed after the bus accepted it
    logic [1:0]  r_beat_cnt;    // index of the next returned beat
    logic [1:0]  r_word;        // word of the line the load asked for
    logic [31:0] r_rd_addr;
    logic        r_rd_type;
    logic        r_resp_valid;
    logic [31:0] r_resp_data;

    logic        w_accept;
    logic        w_hit;
    logic        w_line_req;    // accepted load would be a line fill
    logic [31:0] w_hit_data;
    logic        w_ret_beat;
    logic        w_ret_done;
    logic        w_capture;

    assign w_accept   = req_valid & req_ready;
    // Return beats are only meaningful while waiting on the bus.
    assign w_ret_beat = (r_state == S_BUS_WAIT) & ret_valid;
    assign w_ret_done = w_ret_beat & ret_last;

`ifdef DCACHE_LINE_BUF_EN
    logic [27:0] r_tag;
    logic [31:0] r_line_data [0:3];
    logic        r_line_vld;
    logic        w_fill_beat;
    logic        w_fill_done;
    logic        w_inv_hit_tag;
    logic        w_inv_hit_fill;
    logic        w_unused_inv_lsb;

    assign w_line_req     = ~req_uncached;
    assign w_hit          = w_line_req & r_line_vld & (r_tag == req_pa[31:4]);
    assign w_hit_data     = r_line_data[req_pa[3:2]];
    assign w_fill_beat    = w_ret_beat & r_rd_type;
    assign w_fill_done    = w_ret_done & r_rd_type;
    assign w_inv_hit_tag  = inv_valid & (inv_pa[31:4] == r_tag);
    // On the last fill beat the stored tag is still the old one, so the
    // invalidate has to be compared against the line being installed.
    assign w_inv_hit_fill = inv_valid & (inv_pa[31:4] == r_rd_addr[31:4]);
    assign w_unused_inv_lsb = ^inv_pa[3:0];

    // Line data: plain storage, no reset needed since line_vld guards it.
    always_ff @(posedge clk) begin
        if (w_fill_beat) begin
            r_line_data[r_beat_cnt] <= ret_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tag      <= '0;
            r_line_vld <= 1'b0;
        end else begin
            if (w_fill_done) begin
                r_tag <= r_rd_addr[31:4];
            end
            // Priority: a miss empties the buffer; a completing fill
            // installs the line unless it is invalidated in that same
            // cycle; otherwise an invalidate to the stored tag clears it.
            if (w_accept & ~w_hit & w_line_req) begin
                r_line_vld <= 1'b0;
            end else if (w_fill_done) begin
                r_line_vld <= ~w_inv_hit_fill;
            end else if (w_inv_hit_tag) begin
                r_line_vld <= 1'b0;
            end
        end
    end
`else
    logic w_unused_inputs;

    assign w_line_req      = 1'b0;
    assign w_hit           = 1'b0;
    assign w_hit_data      = '0;
    assign w_unused_inputs = ^{req_uncached, inv_valid, inv_pa};
`endif

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_next = w_hit ? S_RESP : S_BUS_REQ;
                end
            end
            S_BUS_REQ: begin
                // Once the bus took the request it must be drained even if
                // flushed; without rd_rdy a flush simply withdraws it.
                if (rd_rdy) begin
                    w_state_next = S_BUS_WAIT;
                end else if (flush_i) begin
                    w_state_next = S_IDLE;
                end
            end
            S_BUS_WAIT: begin
                if (w_ret_done) begin
                    w_state_next = (r_cancel | flush_i) ? S_IDLE : S_RESP;
                end
            end
            S_RESP: begin
                if (flush_i | dcache_data_ready) begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        req_ready = (r_state == S_IDLE) & ~flush_i;
        rd_req    = (r_state == S_BUS_REQ);
    end

    // ----------------------------------------------------------- datapath
    // Line fills keep the requested word as it streams past; word reads
    // keep their single (last) beat.
    assign w_capture = w_ret_beat & (r_rd_type ? (r_beat_cnt == r_word) : ret_last);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cancel     <= 1'b0;
            r_beat_cnt   <= 2'd0;
            r_word       <= 2'd0;
            r_rd_addr    <= '0;
            r_rd_type    <= 1'b0;
            r_resp_valid <= 1'b0;
            r_resp_data  <= '0;
        end else begin
            if (w_accept) begin
                r_word     <= req_pa[3:2];
                r_beat_cnt <= 2'd0;
                if (!w_hit) begin
                    r_rd_addr <= w_line_req ? {req_pa[31:4], 4'b0000} : req_pa;
                    r_rd_type <= w_line_req;
                end
            end else if (w_ret_beat) begin
                r_beat_cnt <= r_beat_cnt + 2'd1;
            end

            if (w_accept) begin
                r_cancel <= 1'b0;
            end else if (flush_i & (((r_state == S_BUS_REQ) & rd_rdy) |
                                    (r_state == S_BUS_WAIT))) begin
                r_cancel <= 1'b1;
            end

            // Valid simply tracks residency in RESP, so it rises the cycle
            // after a hit or the last beat and drops after ready/flush.
            r_resp_valid <= (w_state_next == S_RESP);

            if (w_accept & w_hit) begin
                r_resp_data <= w_hit_data;
            end else if (w_capture) begin
                r_resp_data <= ret_data;
            end
        end
    end

    assign rd_addr           = r_rd_addr;
    assign rd_type           = r_rd_type;
    assign rd_dcache_data    = r_resp_data;
    assign dcache_data_valid = r_resp_valid;

endmodule

// File: tb/tb_dcache_load_resp.sv
module tb_dcache_load_resp;
`ifdef DCACHE_LINE_BUF_EN
    localparam bit CFG_LINE = 1'b1;
`else
    localparam bit CFG_LINE = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        req_valid;
    logic [31:0] req_pa;
    logic        req_uncached;
    logic        req_ready;
    logic        rd_req;
    logic        rd_type;
    logic [31:0] rd_addr;
    logic        rd_rdy;
    logic        ret_valid;
    logic        ret_last;
    logic [31:0] ret_data;
    logic [31:0] rd_dcache_data;
    logic        dcache_data_valid;
    logic        dcache_data_ready;
    logic        flush_i;
    logic        inv_valid;
    logic [31:0] inv_pa;

    dcache_load_resp dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .req_valid         (req_valid),
        .req_pa            (req_pa),
        .req_uncached      (req_uncached),
        .req_ready         (req_ready),
        .rd_req            (rd_req),
        .rd_type           (rd_type),
        .rd_addr           (rd_addr),
        .rd_rdy            (rd_rdy),
        .ret_valid         (ret_valid),
        .ret_last          (ret_last),
        .ret_data          (ret_data),
        .rd_dcache_data    (rd_dcache_data),
        .dcache_data_valid (dcache_data_valid),
        .dcache_data_ready (dcache_data_ready),
        .flush_i           (flush_i),
        .inv_valid         (inv_valid),
        .inv_pa            (inv_pa)
    );

    int n_checks = 0;
    int n_err    = 0;

    // Expected outputs for the current cycle, set by the stimulus side.
    bit          chk_en = 1'b0;
    bit          e_req_ready, e_rd_req, e_rd_type, e_valid, e_chk_all;
    logic [31:0] e_rd_addr, e_data;

    // Observed deliveries to memory2.
    int          obs_cnt = 0;
    logic [31:0] obs_resp = '0;

    // Behavioural model of the line buffer and of the last load.
    bit          m_vld = 1'b0;
    logic [27:0] m_tag = '0;
    logic [31:0] m_data [4];
    bit          m_last_bus;
    logic [31:0] m_last_addr;
    bit          m_last_type;

    logic [31:0] bb [4];   // beats the bus model returns for the next load

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("req_ready", 32'(req_ready), 32'(e_req_ready));
            check("rd_req", 32'(rd_req), 32'(e_rd_req));
            if (e_rd_req || e_chk_all) begin
                check("rd_addr", rd_addr, e_rd_addr);
                check("rd_type", 32'(rd_type), 32'(e_rd_type));
            end
            check("data_valid", 32'(dcache_data_valid), 32'(e_valid));
            if (e_valid || e_chk_all) begin
                check("resp_data", rd_dcache_data, e_data);
            end
            if (dcache_data_valid && dcache_data_ready) begin
                obs_cnt++;
                obs_resp = rd_dcache_data;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_exp(input bit rr, input bit rq, input logic [31:0] ad, input bit ty,
                           input bit v, input logic [31:0] d, input bit all);
        e_req_ready = rr;
        e_rd_req    = rq;
        e_rd_addr   = ad;
        e_rd_type   = ty;
        e_valid     = v;
        e_data      = d;
        e_chk_all   = all;
    endtask

    function automatic logic [31:0] rand_pa();
        logic [31:0] bases [4];
        logic [1:0]  w;
        bases[0] = 32'h1C00_0100;
        bases[1] = 32'h1C00_0110;
        bases[2] = 32'h4000_0000;
        bases[3] = 32'hBFAF_8000;
        w = 2'($urandom_range(0, 3));
        return bases[$urandom_range(0, 3)] | {28'd0, w, 2'b00};
    endfunction

    // One complete load. fmode: 0 none, 1 flush in BUS_REQ without rd_rdy,
    // 2 flush with rd_rdy, 3 flush on return beat fb, 4 flush in RESP.
    task automatic do_load(input logic [31:0] pa, input bit unc, input int rdy_wait,
                           input int fmode, input int fb, input bit inv_last,
                           input int resp_wait);
        bit          line, hit, cancel;
        logic [31:0] ex_addr, ex_data;
        int          nb;
        line    = CFG_LINE && !unc;
        hit     = line && m_vld && (m_tag == pa[31:4]);
        ex_addr = line ? {pa[31:4], 4'h0} : pa;
        nb      = line ? 4 : 1;
        cancel  = 1'b0;
        ex_data = '0;

        req_valid = 1'b1; req_pa = pa; req_uncached = unc; flush_i = 1'b0;
        set_exp(1, 0, 0, 0, 0, 0, 0);
        tick();
        req_valid = 1'b0; req_pa = $urandom; req_uncached = 1'($urandom_range(0, 1));
        m_last_bus  = !hit;
        m_last_addr = ex_addr;
        m_last_type = line;

        if (hit) begin
            ex_data = m_data[pa[3:2]];
        end else begin
            if (line) m_vld = 1'b0;
            for (int i = 0; i < rdy_wait; i++) begin
                rd_rdy = 1'b0;
                ret_valid = 1'($urandom_range(0, 1)); ret_last = 1'($urandom_range(0, 1));
                ret_data = $urandom;
                set_exp(0, 1, ex_addr, line, 0, 0, 0);
                tick();
            end
            ret_valid = 1'b0; ret_last = 1'b0;
            set_exp(0, 1, ex_addr, line, 0, 0, 0);
            if (fmode == 1) begin
                rd_rdy = 1'b0; flush_i = 1'b1;
                tick();
                flush_i = 1'b0;
                return;
            end
            rd_rdy = 1'b1;
            if (fmode == 2) begin
                flush_i = 1'b1;
                cancel  = 1'b1;
            end
            tick();
            rd_rdy = 1'b0; flush_i = 1'b0;
            for (int b = 0; b < nb; b++) begin
                for (int g = $urandom_range(0, 2); g > 0; g--) begin
                    ret_valid = 1'b0; ret_data = $urandom;
                    set_exp(0, 0, 0, 0, 0, 0, 0);
                    tick();
                end
                ret_valid = 1'b1; ret_data = bb[b]; ret_last = (b == nb - 1);
                if (fmode == 3 && b == fb) begin
                    flush_i = 1'b1;
                    cancel  = 1'b1;
                end
                if (inv_last && b == nb - 1) begin
                    inv_valid = 1'b1;
                    inv_pa    = {pa[31:4], 4'($urandom)};
                end
                set_exp(0, 0, 0, 0, 0, 0, 0);
                tick();
                ret_valid = 1'b0; ret_last = 1'b0; flush_i = 1'b0; inv_valid = 1'b0;
            end
            if (line) begin
                for (int k = 0; k < 4; k++) m_data[k] = bb[k];
                m_tag = pa[31:4];
                m_vld = !inv_last;
            end else if (CFG_LINE && inv_last && pa[31:4] == m_tag) begin
                m_vld = 1'b0;
            end
            ex_data = line ? bb[pa[3:2]] : bb[0];
            if (cancel) return;
        end

        for (int i = 0; i < resp_wait; i++) begin
            dcache_data_ready = 1'b0;
            set_exp(0, 0, 0, 0, 1, ex_data, 0);
            tick();
        end
        set_exp(0, 0, 0, 0, 1, ex_data, 0);
        if (fmode == 4) begin
            flush_i = 1'b1;
            tick();
            flush_i = 1'b0;
            return;
        end
        // A request offered in the ready cycle must not be taken.
        dcache_data_ready = 1'b1; req_valid = 1'b1; req_pa = rand_pa();
        tick();
        dcache_data_ready = 1'b0; req_valid = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            flush_i   = ($urandom_range(0, 3) == 0);
            req_valid = flush_i;
            req_pa    = rand_pa();
            ret_valid = 1'($urandom_range(0, 1)); ret_last = 1'($urandom_range(0, 1));
            ret_data  = $urandom;
            inv_valid = ($urandom_range(0, 3) == 0);
            inv_pa    = ($urandom_range(0, 1) == 1) ? {m_tag, 4'($urandom)} : rand_pa();
            set_exp(!flush_i, 0, 0, 0, 0, 0, 0);
            tick();
            if (CFG_LINE && inv_valid && inv_pa[31:4] == m_tag) m_vld = 1'b0;
        end
        flush_i = 1'b0; req_valid = 1'b0; ret_valid = 1'b0; ret_last = 1'b0; inv_valid = 1'b0;
    endtask

    task automatic inv_cycle(input logic [31:0] pa);
        inv_valid = 1'b1; inv_pa = pa;
        set_exp(1, 0, 0, 0, 0, 0, 0);
        tick();
        if (CFG_LINE && pa[31:4] == m_tag) m_vld = 1'b0;
        inv_valid = 1'b0;
    endtask

    // Reset while waiting for return beats: everything must come back empty.
    task automatic reset_mid_burst(input logic [31:0] pa);
        logic [31:0] ex_addr;
        ex_addr = CFG_LINE ? {pa[31:4], 4'h0} : pa;
        req_valid = 1'b1; req_pa = pa; req_uncached = 1'b0;
        set_exp(1, 0, 0, 0, 0, 0, 0);
        tick();
        req_valid = 1'b0; rd_rdy = 1'b1;
        set_exp(0, 1, ex_addr, CFG_LINE, 0, 0, 0);
        tick();
        rd_rdy = 1'b0;
        if (CFG_LINE) begin
            ret_valid = 1'b1; ret_last = 1'b0; ret_data = 32'hCAFE_0001;
            set_exp(0, 0, 0, 0, 0, 0, 0);
            tick();
            ret_valid = 1'b0;
        end
        set_exp(1, 0, 0, 0, 0, 0, 1);
        #2 rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        m_vld = 1'b0; m_tag = '0;
        for (int i = 0; i < 3; i++) begin
            ret_valid = 1'b1; ret_last = (i == 2); ret_data = $urandom;
            set_exp(1, 0, 0, 0, 0, 0, 1);
            tick();
        end
        ret_valid = 1'b0; ret_last = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: actual=no finish required=finish by 2ms");
        $fatal(1);
    end

    initial begin
        int c0;
        rst_n = 1'b0; req_valid = 1'b0; req_pa = '0; req_uncached = 1'b0;
        rd_rdy = 1'b0; ret_valid = 1'b0; ret_last = 1'b0; ret_data = '0;
        dcache_data_ready = 1'b0; flush_i = 1'b0; inv_valid = 1'b0; inv_pa = '0;
        for (int k = 0; k < 4; k++) m_data[k] = '0;

        // Reset state, during and right after reset.
        @(posedge clk); #1;
        chk_en = 1'b1;
        set_exp(1, 0, 0, 0, 0, 0, 1);
        tick();
        rst_n = 1'b1;
        tick();

        // Cached miss fill, then hit on the same line.
        bb[0] = 32'h11; bb[1] = 32'h22; bb[2] = 32'h33; bb[3] = 32'h44;
        do_load(32'h1C00_0104, 1'b0, 1, 0, 0, 1'b0, 0);
        check("r031_addr", m_last_addr, CFG_LINE ? 32'h1C00_0100 : 32'h1C00_0104);
        check("r031_type", 32'(m_last_type), CFG_LINE ? 32'd1 : 32'd0);
        check("r031_resp", obs_resp, CFG_LINE ? 32'h22 : 32'h11);

        bb[0] = 32'h55; bb[1] = 32'h66; bb[2] = 32'h77; bb[3] = 32'h88;
        do_load(32'h1C00_010C, 1'b0, 0, 0, 0, 1'b0, 0);
        check("r032_bus", 32'(m_last_bus), CFG_LINE ? 32'd0 : 32'd1);
        check("r032_resp", obs_resp, CFG_LINE ? 32'h44 : 32'h55);

        // Consumer stalls for three cycles.
        bb[0] = 32'h99; bb[1] = 32'h9A; bb[2] = 32'h9B; bb[3] = 32'h9C;
        do_load(32'h1C00_0100, 1'b0, 0, 0, 0, 1'b0, 3);
        check("r033_resp", obs_resp, CFG_LINE ? 32'h11 : 32'h99);

        // Uncached word read leaves the line alone.
        bb[0] = 32'hDEAD_BEEF; bb[1] = 32'h1; bb[2] = 32'h2; bb[3] = 32'h3;
        do_load(32'hBFAF_8000, 1'b1, 2, 0, 0, 1'b0, 0);
        check("r035_addr", m_last_addr, 32'hBFAF_8000);
        check("r035_type", 32'(m_last_type), 32'd0);
        check("r035_resp", obs_resp, 32'hDEAD_BEEF);
        bb[0] = 32'hA0; bb[1] = 32'hA1; bb[2] = 32'hA2; bb[3] = 32'hA3;
        do_load(32'h1C00_0108, 1'b0, 0, 0, 0, 1'b0, 0);
        check("r035_line", obs_resp, CFG_LINE ? 32'h33 : 32'hA0);

        // Invalidate, then the line must be fetched again.
        inv_cycle(32'h1C00_0108);
        bb[0] = 32'hB0; bb[1] = 32'hB1; bb[2] = 32'hB2; bb[3] = 32'hB3;
        do_load(32'h1C00_0104, 1'b0, 0, 0, 0, 1'b0, 0);
        check("r036_bus", 32'(m_last_bus), 32'd1);
        check("r036_resp", obs_resp, CFG_LINE ? 32'hB1 : 32'hB0);

        // Flush during the fill: no response, but the line is installed.
        bb[0] = 32'hC0; bb[1] = 32'hC1; bb[2] = 32'hC2; bb[3] = 32'hC3;
        c0 = obs_cnt;
        do_load(32'h2000_0000, 1'b0, 0, 3, CFG_LINE ? 2 : 0, 1'b0, 0);
        check("r034_noresp", 32'(obs_cnt - c0), 32'd0);
        bb[0] = 32'hD0; bb[1] = 32'hD1; bb[2] = 32'hD2; bb[3] = 32'hD3;
        do_load(32'h2000_000C, 1'b0, 0, 0, 0, 1'b0, 0);
        check("r034_bus", 32'(m_last_bus), CFG_LINE ? 32'd0 : 32'd1);
        check("r034_resp", obs_resp, CFG_LINE ? 32'hC3 : 32'hD0);

        // Invalidate in the same cycle as the last beat.
        bb[0] = 32'hE0; bb[1] = 32'hE1; bb[2] = 32'hE2; bb[3] = 32'hE3;
        do_load(32'h3000_0004, 1'b0, 0, 0, 0, 1'b1, 0);
        check("inv_last_resp", obs_resp, CFG_LINE ? 32'hE1 : 32'hE0);
        do_load(32'h3000_0004, 1'b0, 0, 0, 0, 1'b0, 0);
        check("inv_last_bus", 32'(m_last_bus), 32'd1);

        // Flush in BUS_REQ (withdraw / cancel) and in RESP.
        c0 = obs_cnt;
        do_load(32'h4000_0000, 1'b0, 1, 1, 0, 1'b0, 0);
        do_load(32'h4000_0000, 1'b0, 0, 2, 0, 1'b0, 0);
        check("r022_noresp", 32'(obs_cnt - c0), 32'd0);
        bb[0] = 32'hF0; bb[1] = 32'hF1; bb[2] = 32'hF2; bb[3] = 32'hF3;
        do_load(32'h4000_0004, 1'b0, 0, 0, 0, 1'b0, 0);
        check("r022_bus", 32'(m_last_bus), CFG_LINE ? 32'd0 : 32'd1);
        c0 = obs_cnt;
        do_load(32'h4000_0008, 1'b0, 0, 4, 0, 1'b0, 1);
        check("r021_noresp", 32'(obs_cnt - c0), 32'd0);

        // Flush while a request is offered in IDLE.
        req_valid = 1'b1; req_pa = 32'h4000_0004; flush_i = 1'b1;
        set_exp(0, 0, 0, 0, 0, 0, 0);
        tick();
        req_valid = 1'b0; flush_i = 1'b0;

        // Reset in the middle of a burst.
        reset_mid_burst(32'h4000_0000);
        bb[0] = 32'h5A; bb[1] = 32'h5B; bb[2] = 32'h5C; bb[3] = 32'h5D;
        do_load(32'h4000_0004, 1'b0, 0, 0, 0, 1'b0, 0);
        check("r028_bus", 32'(m_last_bus), 32'd1);

        // Randomized traffic.
        for (int t = 0; t < 250; t++) begin
            logic [31:0] pa;
            bit          unc;
            int          fm, fmode, fb;
            for (int k = 0; k < 4; k++) bb[k] = $urandom;
            pa    = rand_pa();
            unc   = ($urandom_range(0, 4) == 0);
            fm    = $urandom_range(0, 9);
            fmode = (fm < 6) ? 0 : fm - 5;
            fb    = $urandom_range(0, (CFG_LINE && !unc) ? 3 : 0);
            do_load(pa, unc, $urandom_range(0, 2), fmode, fb,
                    ($urandom_range(0, 7) == 0), $urandom_range(0, 3));
            idle_cycles($urandom_range(0, 2));
        end

        set_exp(1, 0, 0, 0, 0, 0, 0);
        tick();
        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
